// File: rtl/mem_store_ctrl_pkg.sv
// mem_store_ctrl_pkg: shared bus widths, store size codes, RAM direction codes and store FSM states
package mem_store_ctrl_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeIllegal = 2'b11;
  localparam logic Read = 1'b0;
  localparam logic Write = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FIN = 2'd2} state_t;
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    return size == SizeWord ? 2'd3 : size == SizeHalf ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: byte-serial little-endian store to 8-bit RAM (req_* in, done/err pulse out, bus_req/bus_gnt handshake, addr_ram/dout_ram/wr_ram to RAM)
module mem_store_ctrl
  import mem_store_ctrl_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] addr_ram,
  output logic [7:0]        dout_ram,
  output logic              wr_ram
);
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0] cnt;
  logic [1:0] last;
  logic err_q;
  logic beat;
  assign beat = state == WRITE && bus_gnt;
  always_comb begin
    req_ready = state == IDLE;
    done = state == FIN;
    err = state == FIN && err_q;
    bus_req = state == WRITE;
    wr_ram = beat ? Write : Read;
    addr_ram = beat ? addr_q + ADDR_W'(cnt) : '0;
    dout_ram = beat ? data_q[{cnt, 3'b000} +: 8] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      cnt <= '0;
      last <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q <= req_addr;
          data_q <= req_data;
          cnt <= '0;
          last <= last_idx(req_size);
          err_q <= req_size == SizeIllegal;
          state <= req_size == SizeIllegal ? FIN : WRITE;
        end
        WRITE: if (bus_gnt) begin
          if (cnt == last) state <= FIN;
          else cnt <= cnt + 2'd1;
        end
        FIN: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
